// File: rtl/uart_pkg.sv
// uart_pkg: shared encodings, frame table and CRC polynomial for the UART response scheduler.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FETCH,
        SEND,
        WAIT,
        GAP
`ifdef TX_CRC8_EN
        , CRC
`endif
    } state_t;

    typedef enum logic [2:0] {
        SRC_CMPLTD    = 3'd0,
        SRC_UNCMPLTD  = 3'd1,
        SRC_STATUS    = 3'd2,
        SRC_NONCE     = 3'd3,
        SRC_SIGNATURE = 3'd4,
        SRC_NONE      = 3'd7
    } src_t;

    localparam logic [7:0] BASE_CMPLTD    = 8'h4C;
    localparam logic [7:0] BASE_UNCMPLTD  = 8'h54;
    localparam logic [7:0] BASE_STATUS    = 8'h48;
    localparam logic [7:0] BASE_NONCE     = 8'h68;
    localparam logic [7:0] BASE_SIGNATURE = 8'h6C;

    localparam logic [5:0] LEN_CMPLTD    = 6'd8;
    localparam logic [5:0] LEN_UNCMPLTD  = 6'd8;
    localparam logic [5:0] LEN_STATUS    = 6'd4;
    localparam logic [5:0] LEN_NONCE     = 6'd4;
    localparam logic [5:0] LEN_SIGNATURE = 6'd32;

    localparam logic [7:0] CRC_POLY = 8'h07;

    // Lowest request bit wins: cmpltd has the highest priority.
    function automatic src_t first_src(input logic [4:0] p);
        return p[0] ? SRC_CMPLTD :
               p[1] ? SRC_UNCMPLTD :
               p[2] ? SRC_STATUS :
               p[3] ? SRC_NONCE :
               p[4] ? SRC_SIGNATURE : SRC_NONE;
    endfunction

    function automatic logic [7:0] base_of(input src_t s);
        return s == SRC_CMPLTD   ? BASE_CMPLTD :
               s == SRC_UNCMPLTD ? BASE_UNCMPLTD :
               s == SRC_STATUS   ? BASE_STATUS :
               s == SRC_NONCE    ? BASE_NONCE : BASE_SIGNATURE;
    endfunction

    function automatic logic [5:0] len_of(input src_t s);
        return s == SRC_CMPLTD   ? LEN_CMPLTD :
               s == SRC_UNCMPLTD ? LEN_UNCMPLTD :
               s == SRC_STATUS   ? LEN_STATUS :
               s == SRC_NONCE    ? LEN_NONCE : LEN_SIGNATURE;
    endfunction

endpackage

// File: rtl/crc8_byte.sv
// crc8_byte: CRC-8 accumulator (MSB first, init 0x00), one byte folded in per enabled cycle.
module crc8_byte
    import uart_pkg::*;
(
    input  logic       clk_25,
    input  logic       reset_n,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] din,
    output logic [7:0] crc
);

    logic [7:0] upd;

    always_comb begin
        upd = crc ^ din;
        for (int i = 0; i < 8; i++)
            upd = upd[7] ? {upd[6:0], 1'b0} ^ CRC_POLY : {upd[6:0], 1'b0};
    end

    always_ff @(posedge clk_25 or negedge reset_n)
        if (!reset_n)
            crc <= 8'h00;
        else if (clr)
            crc <= 8'h00;
        else if (en)
            crc <= upd;

endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: fixed-priority scheduler streaming response frames from system RAM to a byte UART.
// Defining TX_CRC8_EN appends a CRC-8 trailer byte to every frame.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int TX_GAP  = 0,
    parameter int RAM_LAT = 1
) (
    input  logic       clk_25,
    input  logic       reset_n,
    input  logic       host_break,
    input  logic [4:0] req,
    input  logic [7:0] ram_byte,
    input  logic       tx_byte_cmplt,
    output logic [7:0] ram_addr,
    output logic [7:0] tx_byte,
    output logic       tx_byte_go,
    output logic       busy,
    output logic       frame_done,
    output logic [2:0] active_src
);

    localparam logic [7:0] FETCH_LAST = 8'(RAM_LAT > 0 ? RAM_LAT - 1 : 0);
    localparam logic [7:0] GAP_LAST   = 8'(TX_GAP > 0 ? TX_GAP - 1 : 0);
    localparam state_t     AFTER_GAP  = RAM_LAT > 0 ? FETCH : SEND;
    localparam state_t     AFTER_WAIT = TX_GAP > 0 ? GAP : AFTER_GAP;

    state_t     state, nxt;
    src_t       src, gnt_src;
    logic [1:0] rst_sync;
    logic       rst_s;
    logic [4:0] pend, gnt;
    logic [5:0] cnt;
    logic [7:0] tmr;
    logic       grant, step, go_d, done_d;

    // Reset asserts asynchronously, releases two clk_25 edges later.
    always_ff @(posedge clk_25 or negedge reset_n)
        if (!reset_n)
            rst_sync <= 2'b00;
        else
            rst_sync <= {rst_sync[0], 1'b1};

    assign rst_s = rst_sync[1];

    always_ff @(posedge clk_25 or negedge rst_s)
        if (!rst_s)
            state <= IDLE;
        else
            state <= nxt;

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = |pend ? LOAD : IDLE;
            LOAD:    nxt = AFTER_GAP;
            FETCH:   nxt = tmr == FETCH_LAST ? SEND : FETCH;
            SEND:    nxt = WAIT;
`ifdef TX_CRC8_EN
            WAIT:    nxt = !tx_byte_cmplt ? WAIT :
                           cnt == 6'd0    ? IDLE :
                           cnt == 6'd1    ? CRC : AFTER_WAIT;
            CRC:     nxt = WAIT;
`else
            WAIT:    nxt = !tx_byte_cmplt ? WAIT :
                           cnt == 6'd1    ? IDLE : AFTER_WAIT;
`endif
            GAP:     nxt = tmr == GAP_LAST ? AFTER_GAP : GAP;
            default: nxt = IDLE;
        endcase
        if (host_break)
            nxt = IDLE;
    end

    assign gnt_src = first_src(pend);
    assign gnt     = 5'd1 << gnt_src;
    assign grant   = state == IDLE && |pend && !host_break;
    assign step    = state == WAIT && tx_byte_cmplt && !host_break;
    assign done_d  = step && nxt == IDLE;
`ifdef TX_CRC8_EN
    assign go_d    = (state == SEND || state == CRC) && !host_break;
`else
    assign go_d    = state == SEND && !host_break;
`endif

    always_ff @(posedge clk_25 or negedge rst_s)
        if (!rst_s) begin
            pend       <= 5'd0;
            src        <= SRC_NONE;
            ram_addr   <= 8'h00;
            cnt        <= 6'd0;
            tmr        <= 8'd0;
            tx_byte    <= 8'h00;
            tx_byte_go <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            // A request coinciding with its own grant re-arms the flag.
            pend       <= host_break ? 5'd0 : (pend & ~(grant ? gnt : 5'd0)) | req;
            tmr        <= nxt == state ? tmr + 8'd1 : 8'd0;
            tx_byte_go <= go_d;
            frame_done <= done_d;
            if (grant) begin
                src      <= gnt_src;
                ram_addr <= base_of(gnt_src);
                cnt      <= len_of(gnt_src);
            end
            if (step) begin
                cnt <= cnt - {5'd0, cnt != 6'd0};
                if (cnt > 6'd1)
                    ram_addr <= ram_addr + 8'd1;
            end
            if (state == SEND)
                tx_byte <= ram_byte;
`ifdef TX_CRC8_EN
            if (state == CRC)
                tx_byte <= crc;
`endif
        end

`ifdef TX_CRC8_EN
    logic [7:0] crc;

    crc8_byte u_crc (
        .clk_25  (clk_25),
        .reset_n (rst_s),
        .clr     (grant),
        .en      (state == SEND),
        .din     (ram_byte),
        .crc     (crc)
    );
`endif

    assign busy       = state != IDLE;
    assign active_src = busy ? src : SRC_NONE;

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: scoreboard bench for uart_tx_sched with RAM and UART responder models.
module tb_uart_tx_sched;

    logic       clk_25 = 1'b0;
    logic       reset_n;
    logic       host_break;
    logic [4:0] req;
    logic [7:0] ram_byte = 8'h00;
    logic       tx_byte_cmplt;
    logic [7:0] ram_addr;
    logic [7:0] tx_byte;
    logic       tx_byte_go;
    logic       busy;
    logic       frame_done;
    logic [2:0] active_src;
    logic       stray = 1'b0;

    typedef struct packed {
        logic       fd;
        logic [2:0] src;
        logic [7:0] addr;
        logic [7:0] data;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   go_seen = 0;
    int   fd_seen = 0;

    logic [7:0] bases [5] = '{8'h4C, 8'h54, 8'h48, 8'h68, 8'h6C};
    int         lens  [5] = '{8, 8, 4, 4, 32};

    uart_tx_sched dut (
        .clk_25        (clk_25),
        .reset_n       (reset_n),
        .host_break    (host_break),
        .req           (req),
        .ram_byte      (ram_byte),
        .tx_byte_cmplt (tx_byte_cmplt),
        .ram_addr      (ram_addr),
        .tx_byte       (tx_byte),
        .tx_byte_go    (tx_byte_go),
        .busy          (busy),
        .frame_done    (frame_done),
        .active_src    (active_src)
    );

    always #20 clk_25 = ~clk_25;

    function automatic logic [7:0] memf(input logic [7:0] a);
        return (a >= 8'h48 && a <= 8'h4B) ? a - 8'h47 : a ^ 8'h5A;
    endfunction

    // Bit-serial reference CRC-8, poly 0x07, init 0x00.
    function automatic logic [7:0] crc_ref(input logic [7:0] base, input int n);
        logic [7:0] c;
        logic [7:0] d;
        logic       fb;
        c = 8'h00;
        for (int i = 0; i < n; i++) begin
            d = memf(base + 8'(i));
            for (int b = 7; b >= 0; b--) begin
                fb = c[7] ^ d[b];
                c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
            end
        end
        return c;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_25);
        #1;
    endtask

    task automatic push_bytes(input int s, input int n);
        for (int i = 0; i < n; i++)
            q.push_back('{1'b0, 3'(s), bases[s] + 8'(i), memf(bases[s] + 8'(i))});
    endtask

    task automatic push_frame(input int s);
        push_bytes(s, lens[s]);
`ifdef TX_CRC8_EN
        q.push_back('{1'b0, 3'(s), bases[s] + 8'(lens[s] - 1), crc_ref(bases[s], lens[s])});
`endif
        q.push_back('{1'b1, 3'(s), 8'h00, 8'h00});
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || q.size() != 0) && n < 3000) begin
            tick();
            n++;
        end
        chk("idle_timeout", n < 3000, 1);
        repeat (3) tick();
    endtask

    task automatic wait_go(input int target);
        int n;
        n = 0;
        while (go_seen < target && n < 500) begin
            tick();
            n++;
        end
        chk("go_timeout", go_seen >= target, 1);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ram_addr"}, ram_addr, 8'h00);
        chk({tag, "_tx_byte"}, tx_byte, 8'h00);
        chk({tag, "_go"}, tx_byte_go, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_frame_done"}, frame_done, 0);
        chk({tag, "_active_src"}, active_src, 3'd7);
    endtask

    // RAM model: one cycle of read latency.
    initial begin
        logic [7:0] a;
        forever begin
            @(negedge clk_25);
            a = ram_addr;
            @(posedge clk_25);
            #1;
            ram_byte = memf(a);
        end
    end

    // UART model: byte-done pulse four cycles after each start strobe.
    initial begin
        int d;
        d = 0;
        tx_byte_cmplt = 1'b0;
        forever begin
            @(posedge clk_25);
            #1;
            tx_byte_cmplt = stray;
            if (tx_byte_go)
                d = 4;
            else if (d > 0) begin
                d--;
                if (d == 0)
                    tx_byte_cmplt = 1'b1;
            end
        end
    end

    // Monitor: every strobe and frame_done pops one expected item.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_25);
            if (tx_byte_go) begin
                go_seen++;
                chk("go_expected", q.size() != 0, 1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    chk("go_kind", e.fd, 0);
                    chk("go_addr", ram_addr, e.addr);
                    chk("go_data", tx_byte, e.data);
                    chk("go_src", active_src, e.src);
                end
            end
            if (frame_done) begin
                fd_seen++;
                chk("fd_expected", q.size() != 0, 1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    chk("fd_kind", e.fd, 1);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, g, f;
        reset_n = 1'b0;
        host_break = 1'b0;
        req = 5'd0;
        repeat (3) tick();
        chk_reset("rst");
        reset_n = 1'b1;
        repeat (4) tick();

        // Status frame and first-strobe latency.
        push_frame(2);
        req = 5'b00100;
        tick();
        req = 5'd0;
        n = 0;
        while (!tx_byte_go && n < 20) begin
            tick();
            n++;
        end
        chk("first_go_latency", n, 4);
        wait_idle();
        chk("busy_after_status", busy, 0);
        chk("src_after_status", active_src, 3'd7);

        // Simultaneous cmpltd and signature requests.
        push_frame(0);
        push_frame(4);
        req = 5'b10001;
        tick();
        req = 5'd0;
        wait_idle();

        // Two nonce requests during a signature frame merge into one frame.
        push_frame(4);
        push_frame(3);
        req = 5'b10000;
        tick();
        req = 5'd0;
        repeat (30) tick();
        req = 5'b01000;
        tick();
        req = 5'd0;
        repeat (100) tick();
        req = 5'b01000;
        tick();
        req = 5'd0;
        wait_idle();

        // Request landing on its own grant cycle yields a second frame.
        push_frame(2);
        push_frame(2);
        req = 5'b00100;
        tick();
        tick();
        req = 5'd0;
        wait_idle();

        // host_break after the second signature byte.
        push_bytes(4, 2);
        g = go_seen;
        req = 5'b10000;
        tick();
        req = 5'd0;
        wait_go(g + 2);
        req = 5'b01000;
        tick();
        req = 5'b00010;
        host_break = 1'b1;
        tick();
        req = 5'd0;
        host_break = 1'b0;
        g = go_seen;
        f = fd_seen;
        chk("break_busy", busy, 0);
        chk("break_src", active_src, 3'd7);
        repeat (80) tick();
        chk("break_no_go", go_seen - g, 0);
        chk("break_no_fd", fd_seen - f, 0);
        chk("break_still_idle", busy, 0);

        // Stray byte-done while idle is ignored.
        stray = 1'b1;
        tick();
        stray = 1'b0;
        repeat (10) tick();
        chk("stray_idle", busy, 0);
        chk("stray_no_go", go_seen - g, 0);

        // Asynchronous reset mid-frame, then a clean status frame.
        push_bytes(4, 3);
        g = go_seen;
        req = 5'b10000;
        tick();
        req = 5'd0;
        wait_go(g + 3);
        tick();
        #3;
        reset_n = 1'b0;
        #1;
        chk_reset("midrst");
        g = go_seen;
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (4) tick();
        chk("midrst_no_go", go_seen - g, 0);
        push_frame(2);
        req = 5'b00100;
        tick();
        req = 5'd0;
        wait_idle();

        chk("queue_empty", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
